// File: rtl/fetch_if.sv
// Fetch-stage bus: redirect/stall control, instruction memory port and IF/ID payload.
interface fetch_if;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc_plus4_o;
  logic        fault_o;
  logic [31:0] fault_pc_o;
  logic [31:0] fetch_count_o;

  modport master (
    input  stall_i, redirect_valid_i, redirect_pc_i, imem_instr_i,
    output imem_addr_o, id_valid_o, id_instr_o, id_pc_o, id_pc_plus4_o,
           fault_o, fault_pc_o, fetch_count_o
  );

  modport slave (
    output stall_i, redirect_valid_i, redirect_pc_i, imem_instr_i,
    input  imem_addr_o, id_valid_o, id_instr_o, id_pc_o, id_pc_plus4_o,
           fault_o, fault_pc_o, fetch_count_o
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, IF/ID register, sticky fetch-fault capture.
module fetch_stage #(
  parameter logic [31:0]  RESET_PC  = 32'h0000_0000,
  parameter int unsigned  MEM_BYTES = 1024
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus
);

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;
  logic        pc_legal;

  assign pc_legal = (pc[1:0] == 2'b00) && (pc <= LAST_PC);

  // Redirect wins over everything; an illegal PC faults even while decode is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      id_valid    <= 1'b0;
      id_instr    <= 32'd0;
      id_pc       <= 32'd0;
      id_pc_plus4 <= 32'd0;
      fault       <= 1'b0;
      fault_pc    <= 32'd0;
      fetch_count <= 32'd0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (bus.redirect_valid_i) begin
            pc       <= bus.redirect_pc_i;
            id_valid <= 1'b0;
          end else if (!pc_legal) begin
            state    <= FAULT;
            fault    <= 1'b1;
            fault_pc <= pc;
            id_valid <= 1'b0;
          end else if (!bus.stall_i) begin
            id_valid    <= 1'b1;
            id_instr    <= bus.imem_instr_i;
            id_pc       <= pc;
            id_pc_plus4 <= pc + 32'd4;
            pc          <= pc + 32'd4;
            fetch_count <= fetch_count + 32'd1;
          end
        end
        FAULT: state <= FAULT;
        default: state <= BOOT;
      endcase
    end
  end

  assign bus.imem_addr_o   = pc;
  assign bus.id_valid_o    = id_valid;
  assign bus.id_instr_o    = id_instr;
  assign bus.id_pc_o       = id_pc;
  assign bus.id_pc_plus4_o = id_pc_plus4;
  assign bus.fault_o       = fault;
  assign bus.fault_pc_o    = fault_pc;
  assign bus.fetch_count_o = fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random stall/redirect traffic against a reference model.
module tb_fetch_stage;
  localparam int unsigned MEM_BYTES = 1024;
  localparam int unsigned WORDS     = MEM_BYTES / 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  fetch_if bus ();

  fetch_stage #(.RESET_PC(32'h0), .MEM_BYTES(MEM_BYTES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [WORDS];
  int n_err = 0;
  int n_chk = 0;

  function automatic logic [31:0] mem_read(logic [31:0] a);
    if (a < MEM_BYTES) return mem[a / 4];
    return 32'hDEAD_BEEF;
  endfunction

  always_comb bus.imem_instr_i = mem_read(bus.imem_addr_o);

  // Reference model: mode 0=boot, 1=run, 2=fault
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_idpc, m_cnt, m_fpc;
  logic        m_valid, m_fault;

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_valid = 0; m_instr = 0; m_idpc = 0;
    m_cnt = 0; m_fault = 0; m_fpc = 0;
  endtask

  task automatic model_step();
    bit legal;
    legal = (m_pc % 4 == 0) && (m_pc <= MEM_BYTES - 4);
    if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1) begin
      if (bus.redirect_valid_i) begin
        m_pc = bus.redirect_pc_i; m_valid = 0;
      end else if (!legal) begin
        m_mode = 2; m_fault = 1; m_fpc = m_pc; m_valid = 0;
      end else if (!bus.stall_i) begin
        m_valid = 1; m_instr = mem[m_pc / 4]; m_idpc = m_pc;
        m_pc = m_pc + 4; m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string ctx);
    chk({ctx, ".addr"},   bus.imem_addr_o, m_pc);
    chk({ctx, ".valid"},  32'(bus.id_valid_o), 32'(m_valid));
    chk({ctx, ".instr"},  bus.id_instr_o, m_instr);
    chk({ctx, ".pc"},     bus.id_pc_o, m_idpc);
    chk({ctx, ".pc4"},    bus.id_pc_plus4_o, (m_idpc == 0 && m_cnt == 0) ? 32'd0 : m_idpc + 32'd4);
    chk({ctx, ".fault"},  32'(bus.fault_o), 32'(m_fault));
    chk({ctx, ".fpc"},    bus.fault_pc_o, m_fpc);
    chk({ctx, ".count"},  bus.fetch_count_o, m_cnt);
  endtask

  task automatic cycle(string ctx);
    @(posedge clk);
    model_step();
    #1;
    check_all(ctx);
  endtask

  task automatic drive(bit st, bit rv, logic [31:0] rpc);
    bus.stall_i = st; bus.redirect_valid_i = rv; bus.redirect_pc_i = rpc;
  endtask

  // Asserts reset between edges and checks values before any clock edge arrives.
  task automatic do_reset(string ctx);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all({ctx, ".rst"});
    chk({ctx, ".rst_valid"}, 32'(bus.id_valid_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < int'(WORDS); i++) mem[i] = $urandom;
    drive(0, 0, 0);
    model_reset();

    // Power-up and sequential fetch of W0..W3
    do_reset("por");
    cycle("boot");
    chk("boot.valid", 32'(bus.id_valid_o), 32'd0);
    chk("boot.addr", bus.imem_addr_o, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle("seq");
      chk("seq.instr_w", bus.id_instr_o, mem[i]);
      chk("seq.pc_w", bus.id_pc_o, 32'(i * 4));
    end
    chk("seq.count4", bus.fetch_count_o, 32'd4);

    // Stall at PC=8
    do_reset("r2");
    cycle("boot2");
    cycle("f0");
    cycle("f1");
    drive(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle("stall");
      chk("stall.idpc", bus.id_pc_o, 32'd4);
      chk("stall.addr", bus.imem_addr_o, 32'd8);
    end
    drive(0, 0, 0);
    cycle("unstall");
    chk("unstall.idpc", bus.id_pc_o, 32'd8);

    // Redirect beats stall
    drive(1, 1, 32'h40);
    cycle("redir");
    chk("redir.valid", 32'(bus.id_valid_o), 32'd0);
    chk("redir.addr", bus.imem_addr_o, 32'h40);
    drive(0, 0, 0);
    cycle("redir_f");
    chk("redir_f.pc", bus.id_pc_o, 32'h40);
    chk("redir_f.pc4", bus.id_pc_plus4_o, 32'h44);

    // Misaligned redirect faults next cycle, then sticks
    drive(0, 1, 32'h102);
    cycle("mis");
    chk("mis.addr", bus.imem_addr_o, 32'h102);
    drive(0, 0, 0);
    cycle("mis_f");
    chk("mis_f.fault", 32'(bus.fault_o), 32'd1);
    chk("mis_f.fpc", bus.fault_pc_o, 32'h102);
    chk("mis_f.valid", 32'(bus.id_valid_o), 32'd0);
    drive(0, 1, 32'h0);
    cycle("sticky");
    cycle("sticky");
    chk("sticky.addr", bus.imem_addr_o, 32'h102);
    drive(0, 0, 0);

    // Reset out of FAULT, then normal run resumes
    do_reset("r3");
    cycle("boot3");
    for (int i = 0; i < 4; i++) cycle("seq3");
    chk("seq3.instr3", bus.id_instr_o, mem[3]);
    chk("seq3.count", bus.fetch_count_o, 32'd4);

    // Run off the end of memory
    drive(0, 1, 32'h3F0);
    cycle("end_redir");
    drive(0, 0, 0);
    for (int i = 0; i < 4; i++) cycle("end_seq");
    chk("end.lastpc", bus.id_pc_o, 32'h3FC);
    chk("end.valid", 32'(bus.id_valid_o), 32'd1);
    cycle("end_f");
    chk("end_f.fault", 32'(bus.fault_o), 32'd1);
    chk("end_f.fpc", bus.fault_pc_o, 32'h400);

    // Random stall/redirect traffic; reset shortly after any fault
    do_reset("r4");
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [31:0] tgt;
      r = int'($urandom_range(0, 99));
      tgt = 32'($urandom_range(0, WORDS - 1)) << 2;
      if (r < 3) tgt = tgt | 32'($urandom_range(1, 3));
      else if (r < 5) tgt = 32'h400 + tgt;
      drive($urandom_range(0, 3) == 0, r < 12, tgt);
      cycle("rand");
      if (m_mode == 2 && $urandom_range(0, 3) == 0) begin
        drive(0, 0, 0);
        do_reset("rrand");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
